dx_latch: RTL
=============

DX_LATCH -- requirements
Module: dx_latch

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: the width of the bubble and flush counters.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port hold, input, 1 bit: global pipeline freeze (multdiv busy).
REQ-005 The block SHALL have port flush, input, 1 bit: taken branch/jump resolved in X; squash the D instruction.
REQ-006 The block SHALL have port stall, input, 1 bit: load-use stall request from the hazard detector.
REQ-007 The block SHALL have port valid_D, input, 1 bit: the D-stage instruction is real, not a bubble.
REQ-008 The block SHALL have ports insn_D, pc_D, a_D and b_D, input, 32 bits each: decoded instruction, PC, and register-file outputs A and B.
REQ-009 The block SHALL have ports insn_X, pc_X, a_X and b_X, output, 32 bits each: latched X-stage copies of the D inputs.
REQ-010 The block SHALL have port valid_X, output, 1 bit: the X-stage instruction is real.
REQ-011 The block SHALL have port op_X, output, 5 bits: insn_X[31:27], combinational from the register.
REQ-012 The block SHALL have port rd_X, output, 5 bits: insn_X[26:22], combinational from the register.
REQ-013 The block SHALL have port bubble_cnt, output, CNT_W bits: count of stall-inserted bubbles.
REQ-014 The block SHALL have port flush_cnt, output, CNT_W bits: count of flush-squashed slots.

Function
REQ-015 Each rising clock edge SHALL perform exactly one action, chosen by priority: reset > hold > flush > stall > load.
REQ-016 Hold SHALL leave every register, including both counters, unchanged.
REQ-017 Flush SHALL load a bubble and increment flush_cnt; bubble_cnt SHALL be unchanged.
REQ-018 Stall SHALL load a bubble and increment bubble_cnt; flush_cnt SHALL be unchanged.
REQ-019 A bubble SHALL set insn_X, pc_X, a_X and b_X to 0 and valid_X to 0; insn 0 is the nop, so op_X and rd_X read 0.
REQ-020 Load SHALL copy insn_D, pc_D, a_D, b_D and valid_D into the X registers; no counter changes.
REQ-021 Load with valid_D=0 SHALL copy the inputs unchanged and SHALL NOT increment any counter.
REQ-022 Latency SHALL be 1 cycle: D inputs sampled at edge N appear on the X outputs after edge N.
REQ-023 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 When flush and stall are asserted together, only the flush action SHALL occur and only flush_cnt SHALL increment.
REQ-025 When hold is asserted together with flush and/or stall, the hold action SHALL occur; the squash takes effect on the first edge after hold deasserts, provided flush/stall is still asserted.
REQ-026 Outputs SHALL change only at rising clock edges; no output SHALL have a combinational path from any input except through the registers.
REQ-027 A stall SHALL insert exactly one bubble per asserted cycle, so N consecutive stall cycles yield N bubbles and bubble_cnt += N.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL zero all X registers, valid_X, bubble_cnt and flush_cnt, regardless of every other input.
REQ-029 A reset asserted mid-stall or mid-hold SHALL take effect on that edge; the next edge after reset deasserts SHALL follow REQ-015 normally.
REQ-030 Before the first reset, the block SHALL NOT drive defined output values.

Verification
REQ-031 The bench SHALL cover this scenario: reset 1 cycle with all inputs nonzero -> all outputs 0.
REQ-032 The bench SHALL cover this scenario: load insn_D=0x40C00005 (op 01000, rd 3), pc_D=0x10, valid_D=1 -> next cycle op_X=5'b01000, rd_X=3, pc_X=0x10, valid_X=1.
REQ-033 The bench SHALL cover this scenario: stall for 3 cycles with valid inputs -> valid_X=0 and insn_X=0 for 3 cycles, bubble_cnt=3, flush_cnt=0.
REQ-034 The bench SHALL cover this scenario: flush and stall asserted in the same cycle -> one bubble, flush_cnt=1, bubble_cnt unchanged.
REQ-035 The bench SHALL cover this scenario: hold for 2 cycles with flush asserted and new D values -> X outputs frozen and counters frozen; the edge after hold drops (flush still 1) -> bubble, flush_cnt+1.
REQ-036 The bench SHALL cover this scenario: with CNT_W=4, apply 20 stall cycles -> bubble_cnt=15 (saturated); then reset -> 0.

Source files
------------

// File: rtl/dx_latch.sv
// D/X pipeline latch: captures the decoded instruction into X, inserting bubbles
// on flush or load-use stall and counting each kind of squashed slot.
module dx_latch #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             stall,
    input  logic             valid_D,
    input  logic [31:0]      insn_D,
    input  logic [31:0]      pc_D,
    input  logic [31:0]      a_D,
    input  logic [31:0]      b_D,
    output logic [31:0]      insn_X,
    output logic [31:0]      pc_X,
    output logic [31:0]      a_X,
    output logic [31:0]      b_X,
    output logic             valid_X,
    output logic [4:0]       op_X,
    output logic [4:0]       rd_X,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      insn_p0;
    logic [31:0]      pc_p0;
    logic [31:0]      a_p0;
    logic [31:0]      b_p0;
    logic             vld_p0;
    logic [CNT_W-1:0] bubble_cnt_p0;
    logic [CNT_W-1:0] flush_cnt_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // D -> X stage boundary; priority reset > hold > flush > stall > load
    always_ff @(posedge clock) begin
        if (reset) begin
            insn_p0       <= '0;
            pc_p0         <= '0;
            a_p0          <= '0;
            b_p0          <= '0;
            vld_p0        <= 1'b0;
            bubble_cnt_p0 <= '0;
            flush_cnt_p0  <= '0;
        end else if (hold) begin
            insn_p0       <= insn_p0;
            pc_p0         <= pc_p0;
            a_p0          <= a_p0;
            b_p0          <= b_p0;
            vld_p0        <= vld_p0;
            bubble_cnt_p0 <= bubble_cnt_p0;
            flush_cnt_p0  <= flush_cnt_p0;
        end else if (flush || stall) begin
            // A bubble is the all-zero nop; flush wins the count when both are set
            insn_p0 <= '0;
            pc_p0   <= '0;
            a_p0    <= '0;
            b_p0    <= '0;
            vld_p0  <= 1'b0;
            if (flush) begin
                flush_cnt_p0 <= sat_inc(flush_cnt_p0);
            end else begin
                bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
            end
        end else begin
            insn_p0 <= insn_D;
            pc_p0   <= pc_D;
            a_p0    <= a_D;
            b_p0    <= b_D;
            vld_p0  <= valid_D;
        end
    end

    assign insn_X     = insn_p0;
    assign pc_X       = pc_p0;
    assign a_X        = a_p0;
    assign b_X        = b_p0;
    assign valid_X    = vld_p0;
    assign op_X       = insn_p0[31:27];
    assign rd_X       = insn_p0[26:22];
    assign bubble_cnt = bubble_cnt_p0;
    assign flush_cnt  = flush_cnt_p0;

endmodule
